// File: rtl/rom_mac_sequencer.sv
// rom_mac_sequencer
//   Dot-product engine for two external 16-entry operand ROMs. A start
//   command walks len address pairs from base1/base2 (wrapping modulo 16).
//   It fetches one operand from each ROM per element and multiplies the
//   pair with a SIZE-cycle shift-add engine. The exact product is then
//   accumulated into acc.
//
//   Optional build macro: MAC_SAT_EN
//     defined   - on accumulator overflow acc saturates to all-ones for the
//                 rest of the command; ovf is set.
//     undefined - acc wraps modulo 2^ACC_W; ovf still flags the carry.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           one-cycle command strobe (sampled in IDLE only)
//   base1, base2    first rom1 / rom2 address of the command
//   len             element count, 0..16
//   addr1, addr2    ROM addresses (valid while en1/en2 are high)
//   en1, en2        ROM enables, high only during the fetch cycle
//   opa, opb        ROM data, combinational from addr/en
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse
//   acc             dot-product result, held until the next accepted start
//   ovf             sticky accumulator overflow flag
module rom_mac_sequencer #(
    parameter int SIZE     = 8,
    parameter int LongSize = 2 * SIZE,
    parameter int ACC_W    = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       base1,
    input  logic [3:0]       base2,
    input  logic [4:0]       len,
    output logic [3:0]       addr1,
    output logic [3:0]       addr2,
    output logic             en1,
    output logic             en2,
    input  logic [SIZE-1:0]  opa,
    input  logic [SIZE-1:0]  opb,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    localparam int CNT_W = $clog2(SIZE + 1);
    // The sum is wide enough for either operand plus one carry bit.
    localparam int SUM_W = ((ACC_W > LongSize) ? ACC_W : LongSize) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MUL,
        S_ACC,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          base1_q, base1_d;
    logic [3:0]          base2_q, base2_d;
    logic [4:0]          len_q, len_d;
    logic [4:0]          idx_q, idx_d;
    logic [LongSize-1:0] shift_opa_q, shift_opa_d;
    logic [SIZE-1:0]     shift_opb_q, shift_opb_d;
    logic [LongSize-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          addr1_q, addr1_d;
    logic [3:0]          addr2_q, addr2_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [SUM_W-1:0]    sum;
    logic                carry;
    logic [4:0]          next_idx;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned; otherwise synthesis would infer latches.
        state_d     = state_q;
        base1_d     = base1_q;
        base2_d     = base2_q;
        len_d       = len_q;
        idx_d       = idx_q;
        shift_opa_d = shift_opa_q;
        shift_opb_d = shift_opb_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        en_d        = 1'b0;
        done_d      = 1'b0;

        sum      = SUM_W'(acc_q) + SUM_W'(prod_q);
        carry    = |sum[SUM_W-1:ACC_W];
        next_idx = idx_q + 5'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base1_d = base1;
                    base2_d = base2;
                    len_d   = len;
                    idx_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    if (len != 5'd0) begin
                        // Addresses/enable are registered, so they are set up
                        // on the way into FETCH and are valid during it.
                        state_d = S_FETCH;
                        en_d    = 1'b1;
                        addr1_d = base1;
                        addr2_d = base2;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                shift_opa_d = LongSize'(opa);
                shift_opb_d = opb;
                prod_d      = '0;
                cnt_d       = '0;
                state_d     = S_MUL;
            end
            S_MUL: begin
                if (shift_opb_q[0]) begin
                    prod_d = prod_q + shift_opa_q;
                end
                shift_opa_d = shift_opa_q << 1;
                shift_opb_d = shift_opb_q >> 1;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SIZE - 1)) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
`ifdef MAC_SAT_EN
                // Once saturated, acc stays pinned for the rest of the command.
                acc_d = (carry || ovf_q) ? '1 : sum[ACC_W-1:0];
`else
                acc_d = sum[ACC_W-1:0];
`endif
                ovf_d = ovf_q | carry;
                idx_d = next_idx;
                if (next_idx == len_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    en_d    = 1'b1;
                    addr1_d = base1_q + next_idx[3:0];
                    addr2_d = base2_q + next_idx[3:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the edge regardless of order.
    // NOTE: all state, including the datapath shift registers, is cleared by
    // reset so an aborted command leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base1_q     <= '0;
            base2_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            shift_opa_q <= '0;
            shift_opb_q <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base1_q     <= base1_d;
            base2_q     <= base2_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            shift_opa_q <= shift_opa_d;
            shift_opb_q <= shift_opb_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign addr1 = addr1_q;
    assign addr2 = addr2_q;
    assign en1   = en_q;
    assign en2   = en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign acc   = acc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_rom_mac_sequencer.sv
// Testbench for rom_mac_sequencer. Two instances run in lockstep on the same
// commands: the default ACC_W=20 build and an ACC_W=16 build that exercises
// accumulator overflow. Each instance has its own ROM model read from shared
// contents. Expected results come from a sum-of-products model and are
// queued when a command is issued. A monitor pops the queues when the DUT
// shows a fetch or done.
module tb_rom_mac_sequencer;

    localparam int SIZE   = 8;
    localparam int ACC_A  = 20;
    localparam int ACC_B  = 16;
    localparam int PER_EL = SIZE + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       base1 = '0;
    logic [3:0]       base2 = '0;
    logic [4:0]       len = '0;

    logic [3:0]       addr1_a, addr2_a, addr1_b, addr2_b;
    logic             en1_a, en2_a, en1_b, en2_b;
    logic [SIZE-1:0]  opa_a, opb_a, opa_b, opb_b;
    logic             busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [ACC_A-1:0] acc_a;
    logic [ACC_B-1:0] acc_b;

    logic [7:0] rom1 [16];
    logic [7:0] rom2 [16];

    assign opa_a = en1_a ? rom1[addr1_a] : '0;
    assign opb_a = en2_a ? rom2[addr2_a] : '0;
    assign opa_b = en1_b ? rom1[addr1_b] : '0;
    assign opb_b = en2_b ? rom2[addr2_b] : '0;

    rom_mac_sequencer #(.SIZE(SIZE), .ACC_W(ACC_A)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base1(base1), .base2(base2), .len(len),
        .addr1(addr1_a), .addr2(addr2_a), .en1(en1_a), .en2(en2_a),
        .opa(opa_a), .opb(opb_a),
        .busy(busy_a), .done(done_a), .acc(acc_a), .ovf(ovf_a)
    );

    rom_mac_sequencer #(.SIZE(SIZE), .ACC_W(ACC_B)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base1(base1), .base2(base2), .len(len),
        .addr1(addr1_b), .addr2(addr2_b), .en1(en1_b), .en2(en2_b),
        .opa(opa_b), .opb(opb_b),
        .busy(busy_b), .done(done_b), .acc(acc_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint acc_a;
        bit     ovf_a;
        longint acc_b;
        bit     ovf_b;
        int     cyc;
    } exp_t;

    typedef struct {
        logic [3:0] a1;
        logic [3:0] a2;
    } addr_t;

    exp_t  res_q[$];
    addr_t addr_q[$];
    bit    active = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Dot product over the ROM contents with plain integer arithmetic.
    function automatic longint dot(input int b1, input int b2, input int l);
        longint total = 0;
        for (int i = 0; i < l; i++) begin
            total += longint'(rom1[(b1 + i) % 16]) * longint'(rom2[(b2 + i) % 16]);
        end
        return total;
    endfunction

    // The running total only grows, so a carry happens iff the total reaches 2^w.
    function automatic void fit(input longint total, input int w, output longint acc, output bit ovf);
        longint lim = longint'(1) << w;
        ovf = (total >= lim);
`ifdef MAC_SAT_EN
        acc = ovf ? lim - 1 : total;
`else
        acc = total % lim;
`endif
    endfunction

    task automatic issue(input int b1, input int b2, input int l, input bit spurious);
        exp_t   e;
        addr_t  a;
        longint total;
        int     n;
        @(negedge clk);
        base1 = 4'(b1);
        base2 = 4'(b2);
        len   = 5'(l);
        start = 1'b1;
        total = dot(b1, b2, l);
        fit(total, ACC_A, e.acc_a, e.ovf_a);
        fit(total, ACC_B, e.acc_b, e.ovf_b);
        e.cyc = cyc + 1 + l * PER_EL;
        res_q.push_back(e);
        for (int i = 0; i < l; i++) begin
            a.a1 = 4'((b1 + i) % 16);
            a.a2 = 4'((b2 + i) % 16);
            addr_q.push_back(a);
        end
        @(posedge clk);
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (active && n < 400) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            // Commands issued while busy must be ignored.
            if (active && spurious && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                base1 = 4'($urandom);
                base2 = 4'($urandom);
                len   = 5'($urandom_range(0, 16));
            end
        end
        start = 1'b0;
        if (active) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done len=%0d", l);
            active = 1'b0;
            res_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr1"}, addr1_a, 0);
        check({tag, "_addr2"}, addr2_a, 0);
        check({tag, "_en1"}, en1_a, 0);
        check({tag, "_en2"}, en2_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_acc"}, acc_a, 0);
        check({tag, "_ovf"}, ovf_a, 0);
        check({tag, "_acc16"}, acc_b, 0);
        check({tag, "_busy16"}, busy_b, 0);
    endtask

    // Monitor: compares fetch addresses, busy and completion results.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t  e;
            addr_t a;
            check("busy", busy_a, active);
            check("busy16", busy_b, active);
            if (en1_a || en2_a) begin
                if (addr_q.size() == 0) begin
                    check("en_unexpected", {en1_a, en2_a}, 0);
                end else begin
                    a = addr_q.pop_front();
                    check("addr1", addr1_a, a.a1);
                    check("addr2", addr2_a, a.a2);
                    check("en_pair", {en1_a, en2_a}, 2'b11);
                end
            end
            if (done_a) begin
                if (res_q.size() == 0) begin
                    check("done_unexpected", done_a, 0);
                end else begin
                    e = res_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("acc", acc_a, e.acc_a);
                    check("ovf", ovf_a, e.ovf_a);
                    check("done16", done_b, 1);
                    check("acc16", acc_b, e.acc_b);
                    check("ovf16", ovf_b, e.ovf_b);
                    check("fetch_count", addr_q.size(), 0);
                    addr_q.delete();
                    active = 1'b0;
                end
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            rom1[i] = 8'($urandom);
            rom2[i] = 8'($urandom);
        end
    endtask

    initial begin
        int b1;
        int b2;
        int l;
        for (int i = 0; i < 16; i++) begin
            rom1[i] = '0;
            rom2[i] = '0;
        end

        // Power-on reset.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // Single element: 0x0F * 0x11 = 0xFF.
        rom1[2] = 8'h0F;
        rom2[5] = 8'h11;
        issue(2, 5, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("acc_hold", acc_a, 255);
        check("done_low_after", done_a, 0);

        // Address wrap 14,15,0,1.
        rom1[14] = 8'd1; rom1[15] = 8'd2; rom1[0] = 8'd3; rom1[1] = 8'd4;
        rom2[14] = 8'd1; rom2[15] = 8'd2; rom2[0] = 8'd3; rom2[1] = 8'd4;
        issue(14, 14, 4, 1'b0);

        // len = 0: done next cycle, acc cleared, no fetch.
        issue(3, 7, 0, 1'b1);
        check("len0_acc", acc_a, 0);

        // Reset during the third MUL cycle aborts with no done pulse.
        fill_random();
        @(negedge clk);
        base1 = 4'd4;
        base2 = 4'd9;
        len   = 5'd5;
        start = 1'b1;
        addr_q.push_back('{a1: 4'd4, a2: 4'd9});
        @(posedge clk);
        active = 1'b1;
        @(negedge clk);                     // FETCH
        start = 1'b0;
        repeat (3) @(negedge clk);          // MUL1..MUL3
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        active = 1'b0;
        res_q.delete();
        addr_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done_a, 0);
        end
        #2 rst_n = 1'b1;
        issue(4, 9, 5, 1'b0);

        // Maximum length with all-ones contents and ignored start pulses.
        for (int i = 0; i < 16; i++) begin
            rom1[i] = 8'hFF;
            rom2[i] = 8'hFF;
        end
        issue(0, 0, 16, 1'b1);
        // Two elements: overflows the 16-bit instance.
        issue(5, 9, 2, 1'b0);

        // Randomized commands.
        for (int k = 0; k < 20; k++) begin
            fill_random();
            b1 = $urandom_range(0, 15);
            b2 = $urandom_range(0, 15);
            l  = $urandom_range(0, 16);
            issue(b1, b2, l, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
